// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: valid/ready front end for a registered ALU; issues one op,
// waits the ALU latency, captures the result and returns it with dbz/illegal flags.
`default_nettype none

module alu_op_sequencer #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 4,
    parameter int LAT    = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [SEL_W-1:0]  cmd_sel,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_carry,
    output logic              rsp_dbz,
    output logic              rsp_illegal,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    localparam int LCW = (LAT < 2) ? 1 : $clog2(LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [LCW-1:0]     lat_q, lat_d;
    logic [DATA_W-1:0]  alu_a_q, alu_a_d;
    logic [DATA_W-1:0]  alu_b_q, alu_b_d;
    logic [SEL_W-1:0]   alu_sel_q, alu_sel_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               rsp_carry_q, rsp_carry_d;
    logic               rsp_dbz_q, rsp_dbz_d;
    logic               rsp_illegal_q, rsp_illegal_d;
    logic [CNT_W-1:0]   op_count_q, op_count_d;

    logic cmd_hs;
    logic cmd_dbz;

    assign cmd_hs  = cmd_valid && (state_q == S_IDLE);
    assign cmd_dbz = (cmd_sel == SEL_W'(3)) && (cmd_b == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            lat_q         <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_sel_q     <= '0;
            rsp_data_q    <= '0;
            rsp_carry_q   <= 1'b0;
            rsp_dbz_q     <= 1'b0;
            rsp_illegal_q <= 1'b0;
            op_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            lat_q         <= lat_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_sel_q     <= alu_sel_d;
            rsp_data_q    <= rsp_data_d;
            rsp_carry_q   <= rsp_carry_d;
            rsp_dbz_q     <= rsp_dbz_d;
            rsp_illegal_q <= rsp_illegal_d;
            op_count_q    <= op_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        lat_d         = lat_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_sel_d     = alu_sel_q;
        rsp_data_d    = rsp_data_q;
        rsp_carry_d   = rsp_carry_q;
        rsp_dbz_d     = rsp_dbz_q;
        rsp_illegal_d = rsp_illegal_q;
        op_count_d    = op_count_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_hs) begin
                    if (cmd_dbz) begin
                        // Divide by zero never reaches the ALU; answer directly.
                        state_d       = S_RESP;
                        rsp_data_d    = '0;
                        rsp_carry_d   = 1'b0;
                        rsp_dbz_d     = 1'b1;
                        rsp_illegal_d = 1'b0;
                    end else begin
                        state_d   = S_ISSUE;
                        alu_a_d   = cmd_a;
                        alu_b_d   = cmd_b;
                        alu_sel_d = cmd_sel;
                        lat_d     = LCW'(LAT);
                    end
                end
            end
            S_ISSUE: begin
                lat_d = lat_q - LCW'(1);
                if (lat_q <= LCW'(1)) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                state_d       = S_RESP;
                rsp_data_d    = alu_out;
                rsp_carry_d   = alu_carry;
                rsp_dbz_d     = 1'b0;
                rsp_illegal_d = (alu_sel_q > SEL_W'(3));
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d    = S_IDLE;
                    op_count_d = op_count_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign rsp_valid   = (state_q == S_RESP);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_sel     = alu_sel_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_carry   = rsp_carry_q;
    assign rsp_dbz     = rsp_dbz_q;
    assign rsp_illegal = rsp_illegal_q;
    assign op_count    = op_count_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural registered ALU behind it.
`default_nettype none

module tb_alu_op_sequencer;

    logic       clock;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_sel;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_sel;
    logic [7:0] m_out;
    logic       m_carry;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_carry;
    logic       rsp_dbz;
    logic       rsp_illegal;
    logic       busy;
    logic [15:0] op_count;

    // Second instance with a narrow counter to exercise wrap-around cheaply.
    logic       c2_valid;
    logic       c2_ready;
    logic [3:0] c2_sel;
    logic [7:0] c2_a;
    logic [7:0] c2_b;
    logic [7:0] c2_alu_a;
    logic [7:0] c2_alu_b;
    logic [3:0] c2_alu_sel;
    logic       c2_rsp_valid;
    logic       c2_rsp_ready;
    logic [7:0] c2_rsp_data;
    logic       c2_rsp_carry;
    logic       c2_rsp_dbz;
    logic       c2_rsp_illegal;
    logic       c2_busy;
    logic [3:0] c2_count;

    int n_checks;
    int n_errors;

    alu_op_sequencer #(.DATA_W(8), .SEL_W(4), .LAT(1), .CNT_W(16)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_sel(cmd_sel), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(m_out), .alu_carry(m_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry),
        .rsp_dbz(rsp_dbz), .rsp_illegal(rsp_illegal),
        .busy(busy), .op_count(op_count)
    );

    alu_op_sequencer #(.DATA_W(8), .SEL_W(4), .LAT(1), .CNT_W(4)) dut_w (
        .clock(clock), .reset(reset),
        .cmd_valid(c2_valid), .cmd_ready(c2_ready),
        .cmd_sel(c2_sel), .cmd_a(c2_a), .cmd_b(c2_b),
        .alu_a(c2_alu_a), .alu_b(c2_alu_b), .alu_sel(c2_alu_sel),
        .alu_out(m_out), .alu_carry(m_carry),
        .rsp_valid(c2_rsp_valid), .rsp_ready(c2_rsp_ready),
        .rsp_data(c2_rsp_data), .rsp_carry(c2_rsp_carry),
        .rsp_dbz(c2_rsp_dbz), .rsp_illegal(c2_rsp_illegal),
        .busy(c2_busy), .op_count(c2_count)
    );

    // Registered ALU model: one-cycle latency, carry is always that of A+B.
    logic [8:0] m_sum;
    assign m_sum = {1'b0, alu_a} + {1'b0, alu_b};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_out   <= 8'h00;
            m_carry <= 1'b0;
        end else begin
            m_carry <= m_sum[8];
            case (alu_sel)
                4'd0:    m_out <= alu_a + alu_b;
                4'd1:    m_out <= alu_a - alu_b;
                4'd2:    m_out <= alu_a * alu_b;
                4'd3:    m_out <= (alu_b != 8'h00) ? alu_a / alu_b : 8'h00;
                default: m_out <= 8'hAC;
            endcase
        end
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command from IDLE; returns cycles from handshake edge to rsp_valid.
    task automatic run_op(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b,
                          output int lat);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_sel   = sel;
        cmd_a     = a;
        cmd_b     = b;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        cmd_a     = 8'h00;
        cmd_b     = 8'h00;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic finish_rsp(input logic [15:0] exp_cnt);
        @(posedge clock); #1;
        check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        check("op_count", 32'(op_count), 32'(exp_cnt));
    endtask

    int lat;
    logic [7:0] held;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_sel   = 4'd0;
        cmd_a     = 8'h00;
        cmd_b     = 8'h00;
        rsp_ready = 1'b1;
        c2_valid  = 1'b0;
        c2_sel    = 4'd0;
        c2_a      = 8'h00;
        c2_b      = 8'h00;
        c2_rsp_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;

        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_sel", 32'(alu_sel), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);

        // add 200+100 -> 44, carry 1
        run_op(4'd0, 8'd200, 8'd100, lat);
        check("add_lat", 32'(lat), 32'd3);
        check("add_data", 32'(rsp_data), 32'd44);
        check("add_carry", 32'(rsp_carry), 32'd1);
        check("add_dbz", 32'(rsp_dbz), 32'd0);
        finish_rsp(16'd1);

        // div 100/7 -> 14
        run_op(4'd3, 8'd100, 8'd7, lat);
        check("div_lat", 32'(lat), 32'd3);
        check("div_data", 32'(rsp_data), 32'd14);
        check("div_dbz", 32'(rsp_dbz), 32'd0);
        check("div_carry", 32'(rsp_carry), 32'd0);
        finish_rsp(16'd2);

        // div 9/0 -> immediate dbz response
        run_op(4'd3, 8'd9, 8'd0, lat);
        check("dbz_lat", 32'(lat), 32'd1);
        check("dbz_data", 32'(rsp_data), 32'd0);
        check("dbz_flag", 32'(rsp_dbz), 32'd1);
        check("dbz_carry", 32'(rsp_carry), 32'd0);
        check("dbz_alu_sel_held", 32'(alu_sel), 32'd3);
        check("dbz_alu_b_held", 32'(alu_b), 32'd7);
        finish_rsp(16'd3);

        // illegal opcode 4'b1010
        run_op(4'b1010, 8'd5, 8'd5, lat);
        check("ill_lat", 32'(lat), 32'd3);
        check("ill_data", 32'(rsp_data), 32'hAC);
        check("ill_flag", 32'(rsp_illegal), 32'd1);
        check("ill_dbz", 32'(rsp_dbz), 32'd0);
        finish_rsp(16'd4);

        // sub 5-7 -> FE; carry is that of 5+7 -> 0
        run_op(4'd1, 8'd5, 8'd7, lat);
        check("sub_data", 32'(rsp_data), 32'hFE);
        check("sub_illegal", 32'(rsp_illegal), 32'd0);
        check("sub_carry", 32'(rsp_carry), 32'd0);
        finish_rsp(16'd5);

        // mul 20*13 = 260 -> 4 (low byte); carry of 20+13 -> 0
        run_op(4'd2, 8'd20, 8'd13, lat);
        check("mul_data", 32'(rsp_data), 32'd4);
        finish_rsp(16'd6);

        // Backpressure: hold rsp_ready low for 10 cycles with a competing command.
        rsp_ready = 1'b0;
        run_op(4'd0, 8'h80, 8'h80, lat);
        check("bp_lat", 32'(lat), 32'd3);
        check("bp_data", 32'(rsp_data), 32'h00);
        check("bp_carry", 32'(rsp_carry), 32'd1);
        held      = rsp_data;
        cmd_valid = 1'b1;
        cmd_sel   = 4'd0;
        cmd_a     = 8'd1;
        cmd_b     = 8'd1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            check("bp_valid_hold", 32'(rsp_valid), 32'd1);
            check("bp_data_hold", 32'(rsp_data), 32'(held));
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        check("bp_alu_a_held", 32'(alu_a), 32'h80);
        check("bp_count_hold", 32'(op_count), 32'd6);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        check("bp_release_valid", 32'(rsp_valid), 32'd0);
        check("bp_release_idle", 32'(cmd_ready), 32'd1);
        check("bp_release_count", 32'(op_count), 32'd7);

        // Reset asserted while the op is in ISSUE.
        cmd_valid = 1'b1;
        cmd_sel   = 4'd0;
        cmd_a     = 8'd50;
        cmd_b     = 8'd60;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        check("issue_busy", 32'(busy), 32'd1);
        check("issue_alu_a", 32'(alu_a), 32'd50);
        reset = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_alu_a", 32'(alu_a), 32'd0);
        check("arst_alu_b", 32'(alu_b), 32'd0);
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_op_count", 32'(op_count), 32'd0);
        repeat (2) begin
            @(posedge clock); #1;
            check("arst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        reset = 1'b1;
        @(posedge clock); #1;
        run_op(4'd0, 8'd1, 8'd2, lat);
        check("post_rst_lat", 32'(lat), 32'd3);
        check("post_rst_data", 32'(rsp_data), 32'd3);
        finish_rsp(16'd1);

        // Narrow counter wraps after 16 completed (divide-by-zero) responses.
        for (int i = 0; i < 16; i++) begin
            c2_valid = 1'b1;
            c2_sel   = 4'd3;
            c2_a     = 8'(i);
            c2_b     = 8'd0;
            @(posedge clock); #1;
            c2_valid = 1'b0;
            if (i == 0) begin
                check("w_dbz_valid", 32'(c2_rsp_valid), 32'd1);
                check("w_dbz_flag", 32'(c2_rsp_dbz), 32'd1);
            end
            @(posedge clock); #1;
            if (i == 14) check("w_count_max", 32'(c2_count), 32'hF);
        end
        check("w_count_wrap", 32'(c2_count), 32'd0);
        check("w_idle", 32'(c2_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
